// File: rtl/sram_ctrl.sv
// sram_ctrl: single-word initiator for a 16-bit asynchronous SRAM, sequencing SETUP/ACCESS/FINISH cycles.
// Define SRAM_CTRL_B2B_EN to accept a new request during FINISH (back-to-back transfers).
module sram_ctrl #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk50mhz,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_data
);
    localparam int CW = $clog2(WAIT_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, FINISH} state_t;

    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [DATA_W-1:0] wdata;
    logic op_we, op_we_d, accept, drive, rd_done;

    always_comb begin
`ifdef SRAM_CTRL_B2B_EN
        req_ready = state == IDLE || state == FINISH;
`else
        req_ready = state == IDLE;
`endif
        accept  = req_valid && req_ready;
        op_we_d = accept ? req_we : op_we;
        rd_done = state == ACCESS && cnt == '0 && !op_we;
        state_n = state == SETUP  ? ACCESS :
                  state == ACCESS ? (cnt == '0 ? FINISH : ACCESS) :
                  accept          ? SETUP : IDLE;
    end

    // Strobes and bus enable are derived from the next state so they are glitch-free registers.
    always_ff @(posedge clk50mhz or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            op_we     <= 1'b0;
            wdata     <= '0;
            sram_addr <= '0;
            sram_we_n <= 1'b1;
            sram_oe_n <= 1'b1;
            drive     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_n;
            op_we     <= op_we_d;
            if (accept) begin
                sram_addr <= req_addr;
                wdata     <= req_wdata;
            end
            cnt       <= state == SETUP ? CNT_LOAD :
                         (state == ACCESS && cnt != '0) ? cnt - CW'(1) : cnt;
            sram_we_n <= !(state_n == ACCESS && op_we_d);
            sram_oe_n <= !(!op_we_d && (state_n == SETUP || state_n == ACCESS));
            drive     <= op_we_d && state_n != IDLE;
            rsp_valid <= rd_done;
            if (rd_done)
                rsp_rdata <= sram_data;
        end
    end

    assign sram_data = drive ? wdata : 'z;
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: scoreboard bench for sram_ctrl at WAIT_CYCLES=1 (dut 0) and WAIT_CYCLES=3 (dut 1),
// each attached to a behavioural asynchronous SRAM.
module tb_sram_ctrl;
`ifdef SRAM_CTRL_B2B_EN
    localparam int B2B = 1;
`else
    localparam int B2B = 0;
`endif

    typedef struct {
        int          d;
        logic [15:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [15:0] req_addr  [2];
    logic [15:0] req_wdata [2];
    logic        rsp_valid [2];
    logic [15:0] rsp_rdata [2];
    logic        sram_we_n [2];
    logic        sram_oe_n [2];
    logic [15:0] sram_addr [2];
    logic [15:0] bus_obs   [2];

    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic        op_we [8];
    logic [15:0] op_a  [8];
    logic [15:0] op_w  [8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_m
        logic [15:0] mem [65536];
        wire  [15:0] bus;
        sram_ctrl #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(g == 0 ? 1 : 3)) u_dut (
            .clk50mhz (clk),
            .rst_n    (rst_n),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_we   (req_we[g]),
            .req_addr (req_addr[g]),
            .req_wdata(req_wdata[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_rdata(rsp_rdata[g]),
            .sram_we_n(sram_we_n[g]),
            .sram_oe_n(sram_oe_n[g]),
            .sram_addr(sram_addr[g]),
            .sram_data(bus)
        );
        assign bus = (!sram_oe_n[g] && sram_we_n[g]) ? mem[sram_addr[g]] : 'z;
        assign bus_obs[g] = bus;
        always @(posedge sram_we_n[g]) mem[sram_addr[g]] <= bus;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Scoreboard monitor plus the strobe exclusivity rule, sampled on the falling edge.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk("bus_excl", {31'd0, !sram_we_n[d] && !sram_oe_n[d]}, 0);
            if (rsp_valid[d]) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL rsp_unexpected: dut%0d got %h expected no response", d, rsp_rdata[d]);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rsp_dut", d, mon_e.d);
                    chk("rsp_data", {16'd0, rsp_rdata[d]}, {16'd0, mon_e.data});
                    chk("rsp_time", cyc, mon_e.due);
                end
            end
        end
    end

    task automatic wait_ready(input int d);
        int k = 0;
        while (!req_ready[d] && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("ready_wait", {31'd0, req_ready[d]}, 1);
    endtask

    // One request with the full bus window checked cycle by cycle; for reads w is the expected data.
    task automatic do_op(input int d, input logic we, input logic [15:0] a, input logic [15:0] w);
        int wc = d ? 3 : 1;
        @(negedge clk);
        wait_ready(d);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = a;
        req_wdata[d] = w;
        @(negedge clk);
        if (!we) exp_q.push_back('{d, w, cyc + wc + 1});
        req_valid[d] = 1'b0;
        req_we[d]    = ~we;
        req_addr[d]  = ~a;
        req_wdata[d] = ~w;
        for (int k = 0; k <= wc + 1; k++) begin
            chk("addr", {16'd0, sram_addr[d]}, {16'd0, a});
            if (we) begin
                chk("we_n", {31'd0, sram_we_n[d]}, (k >= 1 && k <= wc) ? 0 : 1);
                chk("oe_n_wr", {31'd0, sram_oe_n[d]}, 1);
                chk("wdata", {16'd0, bus_obs[d]}, {16'd0, w});
            end else begin
                chk("oe_n", {31'd0, sram_oe_n[d]}, k <= wc ? 0 : 1);
                chk("we_n_rd", {31'd0, sram_we_n[d]}, 1);
            end
            chk("ready_busy", {31'd0, req_ready[d]}, k == wc + 1 ? B2B : 0);
            @(negedge clk);
        end
        chk("ready_idle", {31'd0, req_ready[d]}, 1);
        chk("we_n_idle", {31'd0, sram_we_n[d]}, 1);
        chk("oe_n_idle", {31'd0, sram_oe_n[d]}, 1);
    endtask

    // Continuous req_valid over op_* entries; checks the accept spacing.
    task automatic stream(input int d, input int n);
        int wc = d ? 3 : 1;
        int tp = 0;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            wait_ready(d);
            req_valid[d] = 1'b1;
            req_we[d]    = op_we[i];
            req_addr[d]  = op_a[i];
            req_wdata[d] = op_w[i];
            @(negedge clk);
            if (!op_we[i]) exp_q.push_back('{d, op_w[i], cyc + wc + 1});
            if (i > 0) chk("period", cyc - tp, wc + 3 - B2B);
            tp = cyc;
        end
        req_valid[d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_we[d]    = 1'b0;
            req_addr[d]  = '0;
            req_wdata[d] = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_we_n", {31'd0, sram_we_n[d]}, 1);
            chk("rst_oe_n", {31'd0, sram_oe_n[d]}, 1);
            chk("rst_addr", {16'd0, sram_addr[d]}, 0);
            chk("rst_rsp_valid", {31'd0, rsp_valid[d]}, 0);
            chk("rst_rdata", {16'd0, rsp_rdata[d]}, 0);
            chk("rst_ready", {31'd0, req_ready[d]}, 1);
        end
        rst_n = 1'b1;

        do_op(0, 1'b1, 16'h0012, 16'hBEEF);
        do_op(0, 1'b0, 16'h0012, 16'hBEEF);
        do_op(0, 1'b1, 16'h0012, 16'h1234);
        chk("rdata_hold", {16'd0, rsp_rdata[0]}, 32'h0000BEEF);

        do_op(1, 1'b1, 16'hFFFF, 16'h0001);
        do_op(1, 1'b0, 16'hFFFF, 16'h0001);

        op_we[0] = 1'b1; op_a[0] = 16'h0100; op_w[0] = 16'hCAFE;
        op_we[1] = 1'b0; op_a[1] = 16'h0100; op_w[1] = 16'hCAFE;
        stream(1, 2);

        for (int i = 0; i < 8; i++) begin
            op_we[i] = i < 4;
            op_a[i]  = 16'(i % 4);
            op_w[i]  = 16'(i % 4);
        end
        stream(0, 8);
        repeat (10) @(negedge clk);

        // Abort a write in ACCESS: strobe must release without a clock edge.
        wait_ready(0);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 16'h0055;
        req_wdata[0] = 16'hAAAA;
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("abort_pre_we_n", {31'd0, sram_we_n[0]}, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_we_n", {31'd0, sram_we_n[0]}, 1);
        chk("abort_oe_n", {31'd0, sram_oe_n[0]}, 1);
        chk("abort_addr", {16'd0, sram_addr[0]}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, req_ready[0]}, 1);
        chk("post_rst_rsp_valid", {31'd0, rsp_valid[0]}, 0);
        chk("post_rst_addr", {16'd0, sram_addr[0]}, 0);
        chk("post_rst_rdata", {16'd0, rsp_rdata[0]}, 0);
        repeat (8) @(negedge clk);
        chk("sb_drain", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Synthesizable initiator for the 16-bit asynchronous testram/external SRAM: it drives WE, OE, ADDR and the shared DATA bus.
- Converts single-word read/write requests from the framebuffer/pixel side into correctly sequenced SRAM cycles, and returns read data with a one-cycle valid pulse.
- Sits between VGA scan-out/drawing logic and the memory, in the clk50mhz domain.

Parameters:
- ADDR_W, 16, SRAM address width.
- DATA_W, 16, SRAM data width.
- WAIT_CYCLES, 1, length of the WE/OE strobe window in clocks (must be >=1).

Ports:
- clk50mhz  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; a request transfers when req_valid && req_ready at a rising edge.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle pulse; rsp_rdata is valid.
- rsp_rdata  out  DATA_W  captured read data, held until the next read.
- sram_we_n  out  1  active-low write enable.
- sram_oe_n  out  1  active-low output enable.
- sram_addr  out  ADDR_W  SRAM address.
- sram_data  inout  DATA_W  bidirectional data; high-Z unless the controller is writing.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, sram_we_n=1, sram_oe_n=1, sram_addr=0, sram_data=Z, rsp_valid=0, rsp_rdata=0, wait counter=0.
  - Reset mid-operation aborts immediately: WE/OE deassert without waiting for a clock, and no rsp_valid is issued.
- All SRAM-side outputs are registered, and the data-bus drive enable is also a register, so there are no glitches.
- req_ready is combinational: 1 in IDLE only.
- Request fields are latched on acceptance. Changes on req_* after acceptance are ignored.
- FSM states: IDLE -> SETUP -> ACCESS -> FINISH -> IDLE.
- IDLE:
  - we_n=1, oe_n=1, data=Z.
  - On accept, latch req_we/addr/wdata and go to SETUP.
- SETUP (1 cycle):
  - sram_addr = latched address.
  - Write: data driven with wdata, we_n=1.
  - Read: oe_n=0, data=Z.
  - Load counter = WAIT_CYCLES-1, then go to ACCESS.
- ACCESS (WAIT_CYCLES cycles):
  - Write: we_n=0, data driven.
  - Read: oe_n=0.
  - Counter decrements; when it is 0, go to FINISH.
  - Read data is sampled into rsp_rdata on the edge leaving ACCESS.
- FINISH (1 cycle):
  - we_n=1, oe_n=1, address held.
  - Write: data still driven (hold time).
  - Read: rsp_valid=1 for this cycle only.
  - Then go to IDLE (data released on entry to IDLE).
- Latency:
  - Accept at edge E: read data appears on rsp_rdata and rsp_valid rises after edge E+WAIT_CYCLES+1.
  - The next accept is possible at edge E+WAIT_CYCLES+3 at the earliest (throughput WAIT_CYCLES+3 clocks/word).
- Bus rules:
  - sram_we_n and sram_oe_n are never both 0.
  - sram_data is driven only in write SETUP/ACCESS/FINISH.
  - sram_addr changes only on entry to SETUP and is otherwise held (including in IDLE).
- Counter width is clog2(WAIT_CYCLES)+1. WAIT_CYCLES=1 gives exactly one ACCESS cycle.
- rsp_rdata is unchanged by writes.

Optional Feature:
- SRAM_CTRL_B2B_EN defined: req_ready is also 1 in FINISH.
  - An accept in FINISH goes directly to SETUP, and throughput becomes WAIT_CYCLES+2 clocks/word.
  - The FINISH outputs (we_n=1, oe_n=1, hold data) are still issued that cycle.
  - On write->read back-to-back, the data drive is dropped on entry to the read SETUP.
- Not defined: req_ready only in IDLE, as above.

Test Plan:
- Reset: rst_n=0 during an ACCESS write -> sram_we_n=1 and sram_data=Z within the same cycle. After release: req_ready=1, rsp_valid=0, sram_addr=0.
- Single write, WAIT_CYCLES=1, addr=0x0012, data=0xBEEF:
  - sram_we_n low for exactly 1 clock with sram_addr=0x0012 and sram_data=0xBEEF stable from SETUP through FINISH.
  - req_ready returns 1 three clocks after accept.
- Read-back of 0x0012 from a behavioral SRAM model -> oe_n low for 2 clocks (SETUP+ACCESS), rsp_valid single pulse 2 clocks after accept, rsp_rdata=0xBEEF.
- WAIT_CYCLES=3: write then read addr 0xFFFF data 0x0001 -> we_n low exactly 3 clocks, rsp_valid 4 clocks after read accept, rsp_rdata=0x0001, throughput 6 clocks/word.
- Stream 4 writes to addresses 0..3 (data 0..3), then 4 reads -> rsp_rdata sequence 0,1,2,3. Assertions: never we_n=0 && oe_n=0; sram_data Z whenever oe_n=0.
- With SRAM_CTRL_B2B_EN, WAIT_CYCLES=1: continuous req_valid -> accepts every 3 clocks and the same data integrity holds. Without the macro, accepts every 4 clocks.
